latch_bist: RTL
===============

// Module: latch_bist
// PURPOSE
//  Built-in self-test initiator for the 1-bit D latch (d/clk -> q/nq).
//  Drives a fixed data/enable pattern into a latch under test and reads back q/nq.
//  Classifies mismatches as stuck-at faults and reports pass/fail.
//  Sits beside each latch instance; the latch "clk" (enable) pin is driven by lat_en.
// PARAMETERS
//  SETTLE_CYCLES  2  clk cycles waited after driving before sampling (>=1)
//  ROUNDS         1  number of full 5-step pattern passes per run (>=1)
//  FAIL_W         8  width of saturating fail counter
// PORTS
//  clk        in   1       system clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  start      in   1       one-cycle run request, honoured only in IDLE
//  lat_d      out  1       data to latch d
//  lat_en     out  1       enable to latch clk pin (transparent when 1)
//  lat_q      in   1       latch q readback
//  lat_nq     in   1       latch nq readback
//  busy       out  1       run in progress
//  done       out  1       one-cycle pulse at end of run
//  pass       out  1       1 = last run had zero failing samples; held until next start
//  stuck0_q   out  1       sticky: q read 0 where 1 expected
//  stuck1_q   out  1       sticky: q read 1 where 0 expected
//  stuck0_nq  out  1       sticky: nq read 0 where 1 expected
//  stuck1_nq  out  1       sticky: nq read 1 where 0 expected
//  fail_cnt   out  FAIL_W  failing samples this run, saturating
// BEHAVIOUR
//  - Reset (async, rst_n=0): FSM=IDLE; every output 0. Mid-run reset aborts immediately; no done pulse.
//  - All outputs registered. FSM: IDLE -> DRIVE -> SETTLE -> SAMPLE -> (DRIVE | DONE) -> IDLE.
//  - IDLE: start=1 at an edge -> DRIVE next cycle; busy=1; clears fail_cnt, flags, pass; step=0, round=0.
//  - start ignored while busy=1 (no restart, no flag clear).
//  - Step table (lat_en, lat_d, expected q): 0:(1,0,0) 1:(1,1,1) 2:(0,0,1 hold)
//    3:(1,0,0) 4:(0,1,0 hold). Expected nq = ~expected q.
//  - DRIVE (1 cycle): lat_en/lat_d <= table[step]. SETTLE: exactly SETTLE_CYCLES cycles.
//  - SAMPLE (1 cycle): compare lat_q/lat_nq with expectation. Each mismatch sets the matching stuck flag.
//    fail_cnt += 1 if q OR nq mismatched (one count per sample). Saturates at 2^FAIL_W-1, no wrap.
//  - After SAMPLE: step<4 -> step+1, DRIVE. step==4 and round<ROUNDS-1 -> step=0, round+1, DRIVE.
//    Otherwise -> DONE.
//  - DONE (1 cycle): done=1, busy=0, pass=(fail_cnt==0), lat_en=0, lat_d=0; -> IDLE.
//    Flags, fail_cnt and pass hold until the next accepted start.
//  - Latency: cycles per step = SETTLE_CYCLES+2. done asserted ROUNDS*5*(SETTLE_CYCLES+2)+1 cycles
//    after the edge that accepted start. Defaults: 21.
//  - lat_q/lat_nq X/Z at SAMPLE is a mismatch for the expected value (treated as !=).
// CONFIGURATION
//  LATCH_BIST_SYNC_EN defined: lat_q and lat_nq each pass through a 2-flop synchronizer
//    (reset 0) before comparison. SETTLE is extended by 2 cycles. Default latency becomes 31.
//  LATCH_BIST_SYNC_EN undefined: lat_q/lat_nq are compared directly; latency per formula above.
// TESTING
//  1 Ideal latch model, defaults, start pulse -> done at +21 cycles, pass=1, fail_cnt=0, all flags 0.
//  2 lat_q tied 0, nq ideal -> stuck0_q=1 (steps 1,2), fail_cnt=2, pass=0, other flags 0.
//  3 Always-transparent latch (ignores en) -> steps 2,4 fail: stuck0_q, stuck1_q, stuck0_nq,
//    stuck1_nq all 1; fail_cnt=2.
//  4 ROUNDS=3, FAIL_W=2, lat_q tied 0 -> 6 failing samples, fail_cnt saturates at 3, done at +61.
//  5 start re-pulsed at cycle 10 of a run -> ignored, done still at +21. rst_n=0 at cycle 12 ->
//    all outputs 0 at once, no done. Restart after release -> clean run, pass=1.
//  6 LATCH_BIST_SYNC_EN defined, ideal latch -> done at +31, pass=1.

Source files
------------

// File: rtl/latch_bist.sv
// ----------------------------------------------------------------------------
// latch_bist
//   Built-in self-test initiator for a 1-bit D latch (d / enable -> q / nq).
//   A fixed five-step data/enable pattern is driven into the latch under test.
//   q and nq are read back after a settle interval. Every mismatch sets a
//   sticky stuck-at flag and counts as one failing sample. At the end of the
//   run a one-cycle done pulse is issued and pass is updated.
//
//   Parameters
//     SETTLE_CYCLES  clk cycles waited after driving, before sampling (>=1)
//     ROUNDS         full five-step pattern passes per run (>=1)
//     FAIL_W         width of the saturating fail counter
//
//   Ports
//     clk        in   1       system clock, rising edge
//     rst_n      in   1       asynchronous active-low reset
//     start      in   1       one-cycle run request, honoured only when idle
//     lat_d      out  1       data to the latch d pin
//     lat_en     out  1       enable to the latch clk pin (transparent when 1)
//     lat_q      in   1       latch q readback
//     lat_nq     in   1       latch nq readback
//     busy       out  1       run in progress
//     done       out  1       one-cycle pulse at the end of a run
//     pass       out  1       last run had zero failing samples
//     stuck0_q   out  1       sticky: q read 0 where 1 expected
//     stuck1_q   out  1       sticky: q read 1 where 0 expected
//     stuck0_nq  out  1       sticky: nq read 0 where 1 expected
//     stuck1_nq  out  1       sticky: nq read 1 where 0 expected
//     fail_cnt   out  FAIL_W  failing samples this run, saturating
//
//   Build option
//     LATCH_BIST_SYNC_EN  when defined, lat_q and lat_nq each pass through a
//                         two-flop synchronizer before comparison, and the
//                         settle interval grows by two cycles to cover it.
// ----------------------------------------------------------------------------
module latch_bist #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ROUNDS        = 1,
    parameter int FAIL_W        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              lat_d,
    output logic              lat_en,
    input  logic              lat_q,
    input  logic              lat_nq,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              stuck0_q,
    output logic              stuck1_q,
    output logic              stuck0_nq,
    output logic              stuck1_nq,
    output logic [FAIL_W-1:0] fail_cnt
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
`ifdef LATCH_BIST_SYNC_EN
    localparam int SYNC_EXTRA = 2;
`else
    localparam int SYNC_EXTRA = 0;
`endif
    localparam int SETTLE_TOTAL = SETTLE_CYCLES + SYNC_EXTRA;
    localparam int CNT_W        = $clog2(SETTLE_TOTAL + 1);
    localparam int RND_W        = $clog2(ROUNDS + 1);

    localparam logic [CNT_W-1:0]  LAST_SETTLE = CNT_W'(SETTLE_TOTAL - 1);
    localparam logic [RND_W-1:0]  LAST_ROUND  = RND_W'(ROUNDS - 1);
    localparam logic [2:0]        LAST_STEP   = 3'd4;
    localparam logic [FAIL_W-1:0] FAIL_MAX    = {FAIL_W{1'b1}};

    // FSM encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DRIVE  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_SAMPLE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // ------------------------------------------------------------------------
    // Pattern table: {lat_en, lat_d, expected q}. Steps 2 and 4 close the
    // latch with d opposite to the stored value, so a latch that ignores its
    // enable is caught there.
    // ------------------------------------------------------------------------
    function automatic logic [2:0] step_entry(input logic [2:0] step);
        logic [2:0] entry;
        case (step)
            3'd0:    entry = 3'b100;  // open, write 0
            3'd1:    entry = 3'b111;  // open, write 1
            3'd2:    entry = 3'b001;  // closed, d=0, must hold 1
            3'd3:    entry = 3'b100;  // open, write 0
            3'd4:    entry = 3'b010;  // closed, d=1, must hold 0
            default: entry = 3'b000;
        endcase
        return entry;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [2:0]        state_q,      state_d;
    logic [2:0]        step_q,       step_d;
    logic [RND_W-1:0]  round_q,      round_d;
    logic [CNT_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic              lat_d_q,      lat_d_d;
    logic              lat_en_q,     lat_en_d;
    logic              busy_q,       busy_d;
    logic              done_q,       done_d;
    logic              pass_q,       pass_d;
    logic              stuck0_q_q,   stuck0_q_d;
    logic              stuck1_q_q,   stuck1_q_d;
    logic              stuck0_nq_q,  stuck0_nq_d;
    logic              stuck1_nq_q,  stuck1_nq_d;
    logic [FAIL_W-1:0] fail_cnt_q,   fail_cnt_d;

    // Readback values presented to the comparator
    logic samp_q;
    logic samp_nq;

`ifdef LATCH_BIST_SYNC_EN
    // The latch output may change asynchronously to clk; two flops per bit
    // resolve metastability before the comparator sees it.
    logic [1:0] q_sync_q;
    logic [1:0] nq_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_sync_q  <= 2'b00;
            nq_sync_q <= 2'b00;
        end else begin
            q_sync_q  <= {q_sync_q[0],  lat_q};
            nq_sync_q <= {nq_sync_q[0], lat_nq};
        end
    end

    assign samp_q  = q_sync_q[1];
    assign samp_nq = nq_sync_q[1];
`else
    assign samp_q  = lat_q;
    assign samp_nq = lat_nq;
`endif

    // ------------------------------------------------------------------------
    // Comparator
    // ------------------------------------------------------------------------
    logic [2:0] cur_entry;
    logic       exp_q;
    logic       q_mis;
    logic       nq_mis;

    always_comb begin
        cur_entry = step_entry(step_q);
        exp_q     = cur_entry[0];
        // Case inequality so an X/Z readback counts as a mismatch in
        // simulation; in silicon it reduces to an ordinary compare.
        q_mis     = (samp_q  !== exp_q);
        nq_mis    = (samp_nq !== ~exp_q);
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d starts from its _q value (done from 0) so that no
        // path through the case leaves a signal unassigned and infers a latch.
        state_d      = state_q;
        step_d       = step_q;
        round_d      = round_q;
        settle_cnt_d = settle_cnt_q;
        lat_d_d      = lat_d_q;
        lat_en_d     = lat_en_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        stuck0_q_d   = stuck0_q_q;
        stuck1_q_d   = stuck1_q_q;
        stuck0_nq_d  = stuck0_nq_q;
        stuck1_nq_d  = stuck1_nq_q;
        fail_cnt_d   = fail_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_DRIVE;
                    busy_d      = 1'b1;
                    pass_d      = 1'b0;
                    stuck0_q_d  = 1'b0;
                    stuck1_q_d  = 1'b0;
                    stuck0_nq_d = 1'b0;
                    stuck1_nq_d = 1'b0;
                    fail_cnt_d  = '0;
                    step_d      = 3'd0;
                    round_d     = '0;
                end
            end

            ST_DRIVE: begin
                lat_en_d     = cur_entry[2];
                lat_d_d      = cur_entry[1];
                settle_cnt_d = '0;
                state_d      = ST_SETTLE;
            end

            ST_SETTLE: begin
                if (settle_cnt_q == LAST_SETTLE) begin
                    state_d = ST_SAMPLE;
                end else begin
                    settle_cnt_d = settle_cnt_q + CNT_W'(1);
                end
            end

            ST_SAMPLE: begin
                // A sample reading 1 where 0 was expected is a stuck-at-1
                // symptom, and vice versa.
                if (q_mis) begin
                    if (exp_q) stuck0_q_d = 1'b1;
                    else       stuck1_q_d = 1'b1;
                end
                if (nq_mis) begin
                    if (!exp_q) stuck0_nq_d = 1'b1;
                    else        stuck1_nq_d = 1'b1;
                end
                // One count per sample, however many pins disagreed.
                if ((q_mis || nq_mis) && (fail_cnt_q != FAIL_MAX)) begin
                    fail_cnt_d = fail_cnt_q + FAIL_W'(1);
                end

                if (step_q != LAST_STEP) begin
                    step_d  = step_q + 3'd1;
                    state_d = ST_DRIVE;
                end else if (round_q != LAST_ROUND) begin
                    step_d  = 3'd0;
                    round_d = round_q + RND_W'(1);
                    state_d = ST_DRIVE;
                end else begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                done_d   = 1'b1;
                busy_d   = 1'b0;
                pass_d   = (fail_cnt_q == '0);
                lat_en_d = 1'b0;
                lat_d_d  = 1'b0;
                state_d  = ST_IDLE;
            end

            default: begin
                state_d  = ST_IDLE;
                busy_d   = 1'b0;
                lat_en_d = 1'b0;
                lat_d_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            step_q       <= 3'd0;
            round_q      <= '0;
            settle_cnt_q <= '0;
            lat_d_q      <= 1'b0;
            lat_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            stuck0_q_q   <= 1'b0;
            stuck1_q_q   <= 1'b0;
            stuck0_nq_q  <= 1'b0;
            stuck1_nq_q  <= 1'b0;
            fail_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q      <= state_d;
            step_q       <= step_d;
            round_q      <= round_d;
            settle_cnt_q <= settle_cnt_d;
            lat_d_q      <= lat_d_d;
            lat_en_q     <= lat_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            stuck0_q_q   <= stuck0_q_d;
            stuck1_q_q   <= stuck1_q_d;
            stuck0_nq_q  <= stuck0_nq_d;
            stuck1_nq_q  <= stuck1_nq_d;
            fail_cnt_q   <= fail_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs, all straight from registers
    // ------------------------------------------------------------------------
    assign lat_d     = lat_d_q;
    assign lat_en    = lat_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign stuck0_q  = stuck0_q_q;
    assign stuck1_q  = stuck1_q_q;
    assign stuck0_nq = stuck0_nq_q;
    assign stuck1_nq = stuck1_nq_q;
    assign fail_cnt  = fail_cnt_q;

endmodule
